fifo_push_arbiter: RTL
======================

// Module: fifo_push_arbiter
// PURPOSE
//  Shares the write port of one fifo_flops instance between N_REQ producers.
//  Round-robin arbitration, combinational grant (ready), registered push/Din stage toward the FIFO.
//  Internal occupancy tracking prevents overflow despite the registered push stage.
//  Sits between producer agents and the FIFO; the FIFO pop side remains owned by the consumer.
// PARAMETERS
//  N_REQ  4   number of requesters (>=2)
//  width  16  data width, matches FIFO bits
//  depth  8   FIFO depth, matches FIFO depth
// PORTS
//  clk        in   1            clock, all state on posedge
//  rst        in   1            asynchronous, active-low reset (rst=0 resets)
//  req        in   N_REQ        req[i]=1: requester i holds valid data
//  data_in    in   N_REQ*width  requester i data at [i*width +: width]
//  gnt        out  N_REQ        one-hot/zero grant; req[i]&gnt[i] at posedge = transfer
//  fifo_full  in   1            FIFO full flag
//  fifo_pop   in   1            pop issued to FIFO by consumer
//  fifo_pndng in   1            FIFO non-empty flag
//  push       out  1            registered push to FIFO
//  Din        out  width        registered data to FIFO
//  count      out  $clog2(depth+1)  tracked occupancy incl. in-flight push
//  ovf_err    out  1            sticky: push issued while fifo_full=1
// BEHAVIOUR
//  Reset (rst=0, async):
//   - push=0, Din=0, count=0, ovf_err=0, rr pointer ptr=0.
//   - gnt forced 0 while rst=0.
//  Eligibility:
//   - allow = (count < depth) && !fifo_full.
//  Grant (combinational):
//   - If allow, gnt = one-hot of first i with req[i]=1, searching ptr, ptr+1, ... mod N_REQ; else gnt=0.
//   - gnt never asserted for a requester with req=0.
//  Transfer at posedge when |gnt:
//   - push<=1, Din<=data_in[g]; otherwise push<=0 and Din holds.
//   - Latency: data reaches FIFO Din/push 1 cycle after grant.
//  Pointer:
//   - On transfer of index g, ptr<=(g+1) mod N_REQ; otherwise ptr holds.
//   - Starvation bound: N_REQ-1 grants.
//  Back-to-back:
//   - Requester may keep req=1 and present new data each cycle.
//   - With a single requester, 1 grant/cycle is sustained.
//  Occupancy:
//   - pop_acc = fifo_pop && fifo_pndng.
//   - count <= count + |gnt - pop_acc.
//   - Grant and pop_acc in the same cycle: count unchanged.
//   - pop_acc at count=0 is ignored (count never underflows).
//   - Same-cycle pop does not enable a grant at count==depth (conservative; grant resumes next cycle).
//  Errors:
//   - ovf_err<=1 when push=1 && fifo_full=1 at posedge; cleared only by reset.
//  Reset mid-operation:
//   - An in-flight push is dropped and count clears; the FIFO shares rst so it empties too.
//   - Arbitration restarts at ptr=0.
// TESTING
//  1 Reset: 4 req active, 3 items in flight, rst=0 for 1 cycle -> push=0, gnt=0, count=0, ptr=0 immediately
//  2 Single: req0 two cycles, data 0xA1A1 then 0xB2B2 -> gnt0 at k,k+1; push at k+1,k+2, Din 0xA1A1,0xB2B2
//  3 Fill: req=4'b1111 held, no pop -> grant order 0,1,2,3,0,1,2,3; count=8 then gnt=0; ovf_err=0
//  4 Drain: count=8, one fifo_pop with pndng=1 -> count=7 next cycle, then exactly one grant, count back to 8
//  5 Fairness: req0,req2 held, pops keep count<8 -> grants alternate 0,2,0,2; req1,req3 never granted
//  6 Ext full: fifo_full forced 1 with count=3, req=4'b0001 -> gnt=0, push=0 while forced; resumes after release

Source files
------------

// File: rtl/fifo_push_arbiter.sv
// fifo_push_arbiter: round-robin arbiter that shares one FIFO write port
// between N_REQ producers. Grant is combinational; push/Din to the FIFO are
// registered, and an internal occupancy count covers the in-flight push so the
// FIFO can never be overflowed by the extra pipeline stage.
//
// Ports:
//   clk, rst        clock / asynchronous active-low reset
//   req, data_in    per-requester valid and data (requester i at [i*width +: width])
//   gnt             one-hot or zero grant (combinational), forced 0 in reset
//   fifo_full       FIFO full flag
//   fifo_pop        consumer pop; fifo_pndng FIFO non-empty flag
//   push, Din       registered write port toward the FIFO
//   count           tracked occupancy including an in-flight push
//   ovf_err         sticky: push seen while fifo_full was high
module fifo_push_arbiter #(
   parameter int unsigned N_REQ = 4,
   parameter int unsigned width = 16,
   parameter int unsigned depth = 8
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [N_REQ-1:0]            req,
   input  logic [N_REQ*width-1:0]      data_in,
   output logic [N_REQ-1:0]            gnt,
   input  logic                        fifo_full,
   input  logic                        fifo_pop,
   input  logic                        fifo_pndng,
   output logic                        push,
   output logic [width-1:0]            Din,
   output logic [$clog2(depth+1)-1:0]  count,
   output logic                        ovf_err
);

   localparam int unsigned PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
   localparam int unsigned CW = $clog2(depth + 1);
   localparam logic [CW-1:0] DEPTH_C = CW'(depth);
   localparam logic [PW-1:0] LAST_C  = PW'(N_REQ - 1);

   logic [PW-1:0]    ptr_q, ptr_d;
   logic [CW-1:0]    count_q, count_d;
   logic             push_q, push_d;
   logic [width-1:0] din_q, din_d;
   logic             ovf_q, ovf_d;

   logic [N_REQ-1:0] sel_c;
   logic [PW-1:0]    gidx_c;
   logic             allow_c;
   logic             xfer_c;
   logic             pop_ok_c;

   // Conservative eligibility: a same-cycle pop does not free a slot.
   assign allow_c = (count_q < DEPTH_C) && !fifo_full;

   // Round-robin search starting at ptr_q; first requester found wins.
   always_comb begin
      int unsigned idx;
      logic        found;
      sel_c  = '0;
      gidx_c = '0;
      found  = 1'b0;
      idx    = 0;
      for (int unsigned k = 0; k < N_REQ; k++) begin
         idx = (32'(ptr_q) + k) % N_REQ;
         if (!found && req[idx]) begin
            found       = 1'b1;
            sel_c[idx]  = 1'b1;
            gidx_c      = PW'(idx);
         end
      end
   end

   assign gnt    = (allow_c && rst) ? sel_c : '0;
   assign xfer_c = |gnt;
   // Pops against an empty count are ignored so count never underflows.
   assign pop_ok_c = fifo_pop && fifo_pndng && (count_q != '0);

   // Next-state for the push stage, pointer, occupancy and error flag.
   always_comb begin
      ptr_d   = ptr_q;
      push_d  = 1'b0;
      din_d   = din_q;
      count_d = count_q + CW'(xfer_c) - CW'(pop_ok_c);
      ovf_d   = ovf_q | (push_q & fifo_full);
      if (xfer_c) begin
         push_d = 1'b1;
         din_d  = data_in[32'(gidx_c)*width +: width];
         ptr_d  = (gidx_c == LAST_C) ? '0 : PW'(gidx_c + PW'(1));
      end
   end

   // State registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ptr_q   <= '0;
         count_q <= '0;
         push_q  <= 1'b0;
         din_q   <= '0;
         ovf_q   <= 1'b0;
      end else begin
         ptr_q   <= ptr_d;
         count_q <= count_d;
         push_q  <= push_d;
         din_q   <= din_d;
         ovf_q   <= ovf_d;
      end
   end

   assign push    = push_q;
   assign Din     = din_q;
   assign count   = count_q;
   assign ovf_err = ovf_q;

endmodule
